// File: rtl/corr_intr_gen_pkg.sv
// Shared definitions for the correlator interrupt generator and the sclk-side
// register map: state encoding, control-word layout and the epoch-counter width.
package corr_intr_gen_pkg;

  localparam int DIV_W_DEF   = 3;
  localparam int RESTART_IDX = DIV_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2,
    ST_OVERRUN = 2'd3
  } irq_state_e;

  // Counter must reach (1 << (2^div_w - 1)) - 1, which needs 2^div_w - 1 bits.
  function automatic int ecnt_width(input int div_w);
    return (1 << div_w) - 1;
  endfunction

endpackage

// File: rtl/corr_epoch_div.sv
// Epoch divider: counts epochs, flags the terminal epoch of each period and
// holds the shadow divider select, reloaded only at period boundaries or restart.
module corr_epoch_div
  import corr_intr_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             dclk,
  input  logic             reset_n,
  input  logic             active,
  input  logic             restart,
  input  logic             epoch,
  input  logic [DIV_W-1:0] div_sel,
  output logic             period_done,
  output logic [DIV_W-1:0] div_cur
);

  localparam int ECNT_W = ecnt_width(DIV_W);

  logic [ECNT_W-1:0] ecnt_q, ecnt_d;
  logic [DIV_W-1:0]  div_cur_q, div_cur_d;
  logic [ECNT_W:0]   span_m1;
  logic [ECNT_W-1:0] tc;

  assign span_m1     = ((ECNT_W+1)'(1) << div_cur_q) - (ECNT_W+1)'(1);
  assign tc          = span_m1[ECNT_W-1:0];
  assign period_done = active && epoch && !restart && (ecnt_q == tc);
  assign div_cur     = div_cur_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    ecnt_d    = ecnt_q;
    div_cur_d = div_cur_q;
    if (restart || period_done) begin
      ecnt_d    = '0;
      div_cur_d = div_sel;
    end else if (active && epoch) begin
      ecnt_d = ecnt_q + ECNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      ecnt_q    <= '0;
      div_cur_q <= '0;
    end else begin
      ecnt_q    <= ecnt_d;
      div_cur_q <= div_cur_d;
    end
  end

endmodule

// File: rtl/corr_intr_gen.sv
// Correlator-domain interrupt generator: divides epochs into periods, raises a
// level interrupt and tracks acknowledges and overruns.
module corr_intr_gen
  import corr_intr_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             dclk,
  input  logic             reset_n,
  input  logic             epoch,
  input  logic [DIV_W:0]   intr_cntl_sync,
  input  logic             intr_cntl_rd_en_sync,
  output logic             irq,
  output logic             irq_pulse,
  output logic             overrun,
  output logic [CNT_W-1:0] period_cnt,
  output logic [DIV_W-1:0] div_cur
);

  irq_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic             irq_pulse_q, irq_pulse_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;

  logic             restart;
  logic             ack;
  logic [DIV_W-1:0] div_sel;
  logic             period_done;

  assign restart = intr_cntl_sync[DIV_W];
  assign div_sel = intr_cntl_sync[DIV_W-1:0];
  assign ack     = intr_cntl_rd_en_sync;

  corr_epoch_div #(.DIV_W(DIV_W)) u_epoch_div (
    .dclk        (dclk),
    .reset_n     (reset_n),
    .active      (state_q != ST_IDLE),
    .restart     (restart),
    .epoch       (epoch),
    .div_sel     (div_sel),
    .period_done (period_done),
    .div_cur     (div_cur)
  );

  always_comb begin
    state_d      = state_q;
    irq_pulse_d  = 1'b0;
    period_cnt_d = period_cnt_q;
    if (restart) begin
      state_d      = ST_ARMED;
      period_cnt_d = '0;
    end else begin
      if (period_done) begin
        irq_pulse_d  = 1'b1;
        period_cnt_d = period_cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_ARMED:   if (period_done) state_d = ST_PENDING;
        ST_PENDING: begin
          if (period_done && !ack) state_d = ST_OVERRUN;
          else if (ack && !period_done) state_d = ST_ARMED;
        end
        ST_OVERRUN: begin
          if (ack) state_d = period_done ? ST_PENDING : ST_ARMED;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
    // irq/overrun are decoded from the next state so they register alongside it.
    irq_d     = (state_d == ST_PENDING) || (state_d == ST_OVERRUN);
    overrun_d = (state_d == ST_OVERRUN);
  end

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      irq_q        <= 1'b0;
      overrun_q    <= 1'b0;
      irq_pulse_q  <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      overrun_q    <= overrun_d;
      irq_pulse_q  <= irq_pulse_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign irq        = irq_q;
  assign overrun    = overrun_q;
  assign irq_pulse  = irq_pulse_q;
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_corr_intr_gen.sv
// Directed self-checking bench for corr_intr_gen with hand-computed expectations.
module tb_corr_intr_gen;

  localparam int DIV_W = 3;
  localparam int CNT_W = 16;

  logic             dclk;
  logic             reset_n;
  logic             epoch;
  logic             rs;
  logic [DIV_W-1:0] sel;
  logic [DIV_W:0]   intr_cntl_sync;
  logic             intr_cntl_rd_en_sync;
  logic             irq;
  logic             irq_pulse;
  logic             overrun;
  logic [CNT_W-1:0] period_cnt;
  logic [DIV_W-1:0] div_cur;

  int n_checks = 0;
  int n_errors = 0;

  assign intr_cntl_sync = {rs, sel};

  corr_intr_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .dclk                 (dclk),
    .reset_n              (reset_n),
    .epoch                (epoch),
    .intr_cntl_sync       (intr_cntl_sync),
    .intr_cntl_rd_en_sync (intr_cntl_rd_en_sync),
    .irq                  (irq),
    .irq_pulse            (irq_pulse),
    .overrun              (overrun),
    .period_cnt           (period_cnt),
    .div_cur              (div_cur)
  );

  initial begin
    dclk = 1'b0;
    forever #5 dclk = ~dclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are observed 1 ns after the edge.
  task automatic tick(input logic ep, input logic rst_strobe, input logic ak);
    epoch                = ep;
    rs                   = rst_strobe;
    intr_cntl_rd_en_sync = ak;
    @(posedge dclk);
    #1;
    epoch                = 1'b0;
    rs                   = 1'b0;
    intr_cntl_rd_en_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n              = 1'b0;
    epoch                = 1'b0;
    rs                   = 1'b0;
    sel                  = '0;
    intr_cntl_rd_en_sync = 1'b0;
    repeat (3) @(posedge dclk);
    #1;
    reset_n = 1'b1;

    // Reset state, then epochs and acks without a restart stay idle.
    check("rst_irq", irq, 0);
    check("rst_pulse", irq_pulse, 0);
    check("rst_ovr", overrun, 0);
    check("rst_pcnt", period_cnt, 0);
    check("rst_divcur", div_cur, 0);
    sel = 3'd0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, i[0]);
      check("idle_pulse", irq_pulse, 0);
    end
    check("idle_irq", irq, 0);
    check("idle_pcnt", period_cnt, 0);
    check("idle_divcur", div_cur, 0);

    // div_sel=2: four epochs five cycles apart complete one period.
    sel = 3'd2;
    tick(1'b0, 1'b1, 1'b0);
    check("d2_divcur", div_cur, 2);
    check("d2_irq0", irq, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      idle(4);
      check("d2_irq_early", irq, 0);
    end
    tick(1'b1, 1'b0, 1'b0);
    check("d2_irq", irq, 1);
    check("d2_pulse", irq_pulse, 1);
    check("d2_pcnt", period_cnt, 1);
    idle(1);
    check("d2_pulse_width", irq_pulse, 0);
    check("d2_irq_hold", irq, 1);
    tick(1'b0, 1'b0, 1'b1);
    check("d2_ack_irq", irq, 0);

    // div_sel=0: back-to-back epochs, overrun after the second completion.
    sel = 3'd0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("d0_p1", irq_pulse, 1);
    check("d0_ovr1", overrun, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("d0_p2", irq_pulse, 1);
    check("d0_ovr2", overrun, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("d0_p3", irq_pulse, 1);
    check("d0_pcnt", period_cnt, 3);
    check("d0_ovr3", overrun, 1);
    idle(1);
    check("d0_pulse_end", irq_pulse, 0);
    tick(1'b0, 1'b0, 1'b1);
    check("d0_ack_irq", irq, 0);
    check("d0_ack_ovr", overrun, 0);

    // div_sel=1: ack coincident with a completing epoch while PENDING.
    sel = 3'd1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("sim_pend_irq", irq, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("sim_mid_pulse", irq_pulse, 0);
    tick(1'b1, 1'b0, 1'b1);
    check("sim_irq", irq, 1);
    check("sim_pulse", irq_pulse, 1);
    check("sim_ovr", overrun, 0);
    check("sim_pcnt", period_cnt, 2);
    tick(1'b0, 1'b0, 1'b1);
    check("sim_ack_irq", irq, 0);

    // div_sel 1->3 mid-period takes effect only at the boundary.
    sel = 3'd1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    sel = 3'd3;
    idle(1);
    check("chg_divcur_old", div_cur, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("chg_pulse1", irq_pulse, 1);
    check("chg_pcnt1", period_cnt, 1);
    check("chg_divcur_new", div_cur, 3);
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("chg_no_pulse", irq_pulse, 0);
    end
    check("chg_pcnt_hold", period_cnt, 1);
    check("chg_irq_low", irq, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("chg_pulse2", irq_pulse, 1);
    check("chg_pcnt2", period_cnt, 2);

    // Restart with a completing epoch and ack while in OVERRUN.
    sel = 3'd0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("rs_pre_ovr", overrun, 1);
    tick(1'b1, 1'b1, 1'b1);
    check("rs_irq", irq, 0);
    check("rs_ovr", overrun, 0);
    check("rs_pcnt", period_cnt, 0);
    check("rs_pulse", irq_pulse, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("rs_armed_pulse", irq_pulse, 1);
    check("rs_armed_pcnt", period_cnt, 1);

    // period_cnt wraps silently from 0xFFFF to 0.
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 65535; i++) tick(1'b1, 1'b0, 1'b0);
    check("wrap_max", period_cnt, 32'hFFFF);
    tick(1'b1, 1'b0, 1'b0);
    check("wrap_zero", period_cnt, 0);
    check("wrap_pulse", irq_pulse, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
